// File: rtl/alu_pkg.sv
// Shared types for the ALU issue arbiter: ALU control codes, legality check, requester count.
package alu_pkg;

  localparam int NREQ = 2;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_SUB = 4'b0010,
    ALU_SLT = 4'b0110,
    ALU_NOR = 4'b1100
  } alu_op_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_SUB, ALU_SLT, ALU_NOR: is_legal_op = 1'b1;
      default:                                    is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way grant for the shared ALU. Round-robin on a last-grant pointer, or fixed
// priority to requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_rr_arbiter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] accept,
  output logic [NREQ-1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = ^{clk, rst_n, accept};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    if (req[0])      grant = 2'b01;
    else if (req[1]) grant = 2'b10;
  end
`else
  logic lp;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n)         lp <= 1'b1;
    else if (accept[0]) lp <= 1'b0;
    else if (accept[1]) lp <= 1'b1;
  end

  // Contention goes to the requester that did not win last; lp resets to 1 so 0 wins first.
  always_comb begin
    grant = req;
    if (&req) grant = lp ? 2'b01 : 2'b10;
  end
`endif

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU between two requesters through an issue register (S1) and a result
// register (S2). Build option ALU_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*4-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*WIDTH-1:0] req_imm,
  input  logic [NREQ-1:0]       req_alusrc,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  input  logic [NREQ-1:0]       flush,
  output logic [WIDTH-1:0]      alu_reg_data1,
  output logic [WIDTH-1:0]      alu_reg_data2,
  output logic [WIDTH-1:0]      alu_imm,
  output logic                  alu_alusrc,
  output logic [3:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_overflow,
  output logic                  rsp_err,
  output logic [TAG_W-1:0]      rsp_tag
);

  typedef struct packed {
    logic             owner;
    logic [3:0]       op;
    logic             alusrc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] imm;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             owner;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             err;
    logic [TAG_W-1:0] tag;
  } s2_t;

  logic            s1_valid, s2_valid;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic            advance, s1_free, s1_legal, acc_idx;
  logic [NREQ-1:0] grant, acc;

  assign advance   = ~s2_valid | rsp_ready[s2_q.owner];
  assign s1_free   = ~s1_valid | advance;
  assign req_ready = grant & {NREQ{s1_free}} & ~flush;
  assign acc       = req_valid & req_ready;
  assign acc_idx   = acc[1];
  assign s1_legal  = is_legal_op(s1_q.op);

  alu_rr_arbiter u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .accept (acc),
    .grant  (grant)
  );

  always_comb begin
    s1_d.owner  = acc_idx;
    s1_d.op     = acc_idx ? req_op[7:4]               : req_op[3:0];
    s1_d.alusrc = acc_idx ? req_alusrc[1]             : req_alusrc[0];
    s1_d.a      = acc_idx ? req_a[WIDTH +: WIDTH]     : req_a[0 +: WIDTH];
    s1_d.b      = acc_idx ? req_b[WIDTH +: WIDTH]     : req_b[0 +: WIDTH];
    s1_d.imm    = acc_idx ? req_imm[WIDTH +: WIDTH]   : req_imm[0 +: WIDTH];
    s1_d.tag    = acc_idx ? req_tag[TAG_W +: TAG_W]   : req_tag[0 +: TAG_W];
  end

  // An illegal op runs the ALU as AND but its response is overridden to a fixed error shape.
  always_comb begin
    s2_d.owner    = s1_q.owner;
    s2_d.tag      = s1_q.tag;
    s2_d.err      = ~s1_legal;
    s2_d.result   = s1_legal ? alu_result : '0;
    s2_d.zero     = s1_legal ? alu_zero : 1'b1;
    s2_d.overflow = s1_legal & alu_overflow;
  end

  // Flush of an owner overrides both the hold path and the S1-to-S2 move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (|acc)                               s1_valid <= 1'b1;
      else if (advance || flush[s1_q.owner])  s1_valid <= 1'b0;

      if (advance)                 s2_valid <= s1_valid & ~flush[s1_q.owner];
      else if (flush[s2_q.owner])  s2_valid <= 1'b0;
    end
  end

  // NOTE: payload registers carry no reset; they are only observed behind their valid bit.
  always_ff @(posedge clk) begin
    if (|acc)   s1_q <= s1_d;
    if (advance) s2_q <= s2_d;
  end

  assign alu_ctrl      = (s1_valid && s1_legal) ? s1_q.op : ALU_AND;
  assign alu_reg_data1 = s1_valid ? s1_q.a   : '0;
  assign alu_reg_data2 = s1_valid ? s1_q.b   : '0;
  assign alu_imm       = s1_valid ? s1_q.imm : '0;
  assign alu_alusrc    = s1_valid & s1_q.alusrc;

  assign rsp_valid    = {s2_valid & s2_q.owner, s2_valid & ~s2_q.owner};
  assign rsp_result   = s2_q.result;
  assign rsp_zero     = s2_q.zero;
  assign rsp_overflow = s2_q.overflow;
  assign rsp_err      = s2_q.err;
  assign rsp_tag      = s2_q.tag;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; honours ALU_ARB_FIXED_PRIO_EN when defined.
module tb_alu_issue_arbiter;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [1:0]         req_valid, req_ready, req_alusrc, flush, rsp_valid, rsp_ready;
  logic [7:0]         req_op;
  logic [2*WIDTH-1:0] req_a, req_b, req_imm;
  logic [2*TAG_W-1:0] req_tag;
  logic [WIDTH-1:0]   alu_reg_data1, alu_reg_data2, alu_imm, alu_result, rsp_result;
  logic               alu_alusrc, alu_zero, alu_overflow, rsp_zero, rsp_overflow, rsp_err;
  logic [3:0]         alu_ctrl;
  logic [TAG_W-1:0]   rsp_tag;

  int total = 0;
  int bad   = 0;

  logic [3:0] legal_ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100};

  always #5 clk = ~clk;

  alu_issue_arbiter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_imm(req_imm), .req_alusrc(req_alusrc),
    .req_tag(req_tag), .flush(flush),
    .alu_reg_data1(alu_reg_data1), .alu_reg_data2(alu_reg_data2), .alu_imm(alu_imm),
    .alu_alusrc(alu_alusrc), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
  );

  // Behavioural ALU returning {overflow, zero, result}.
  function automatic logic [WIDTH+1:0] alu_fn(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic v;
    v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        r = a - b;
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1100: r = ~(a | b);
      default: r = '0;
    endcase
    return {v, (r == '0), r};
  endfunction

  function automatic bit legal(input logic [3:0] op);
    foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  assign {alu_overflow, alu_zero, alu_result} =
    alu_fn(alu_ctrl, alu_reg_data1, alu_alusrc ? alu_imm : alu_reg_data2);

  // Transaction model: each slot holds the request and the response it must produce.
  typedef struct {
    bit               valid;
    int               owner;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] a, b, imm;
    bit               alusrc;
    logic [WIDTH-1:0] result;
    bit               zero, ovf, err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t     m_s1, m_s2;
  bit         m_lp, m_adv;
  logic [1:0] exp_req_ready, exp_rsp_valid;

  task automatic model_eval();
    bit free;
    int g;
    m_adv = !m_s2.valid || rsp_ready[m_s2.owner];
    free  = !m_s1.valid || m_adv;
    g = -1;
    if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = m_lp ? 0 : 1;
`endif
    end else if (req_valid[0]) g = 0;
    else if (req_valid[1])     g = 1;
    exp_req_ready = 2'b00;
    if (g >= 0 && free && !flush[g]) exp_req_ready[g] = 1'b1;
    exp_rsp_valid = 2'b00;
    if (m_s2.valid) exp_rsp_valid[m_s2.owner] = 1'b1;
  endtask

  task automatic model_update();
    int acc;
    logic [WIDTH+1:0] r;
    model_eval();
    if (!rst_n) begin
      m_s1.valid = 0;
      m_s2.valid = 0;
      m_lp = 1'b1;
      return;
    end
    acc = -1;
    for (int i = 0; i < 2; i++) if (exp_req_ready[i] && req_valid[i]) acc = i;
    if (m_adv) begin
      if (m_s1.valid && !flush[m_s1.owner]) m_s2 = m_s1;
      else m_s2.valid = 0;
    end else if (m_s2.valid && flush[m_s2.owner]) m_s2.valid = 0;
    if (acc >= 0) begin
      m_s1.valid  = 1;
      m_s1.owner  = acc;
      m_s1.a      = req_a[acc*WIDTH +: WIDTH];
      m_s1.b      = req_b[acc*WIDTH +: WIDTH];
      m_s1.imm    = req_imm[acc*WIDTH +: WIDTH];
      m_s1.alusrc = req_alusrc[acc];
      m_s1.tag    = req_tag[acc*TAG_W +: TAG_W];
      m_s1.err    = !legal(req_op[acc*4 +: 4]);
      m_s1.ctrl   = m_s1.err ? 4'b0000 : req_op[acc*4 +: 4];
      r = alu_fn(m_s1.ctrl, m_s1.a, m_s1.alusrc ? m_s1.imm : m_s1.b);
      m_s1.result = m_s1.err ? '0 : r[WIDTH-1:0];
      m_s1.zero   = m_s1.err ? 1'b1 : r[WIDTH];
      m_s1.ovf    = m_s1.err ? 1'b0 : r[WIDTH+1];
      m_lp = (acc == 1);
    end else if (m_s1.valid && (m_adv || flush[m_s1.owner])) m_s1.valid = 0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 2'b00; flush = 2'b00; rsp_ready = 2'b11;
    req_op = '0; req_a = '0; req_b = '0; req_imm = '0; req_alusrc = '0; req_tag = '0;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] imm,
                         input logic src, input logic [TAG_W-1:0] tag);
    req_op[i*4 +: 4]             = op;
    req_a[i*WIDTH +: WIDTH]      = a;
    req_b[i*WIDTH +: WIDTH]      = b;
    req_imm[i*WIDTH +: WIDTH]    = imm;
    req_alusrc[i]                = src;
    req_tag[i*TAG_W +: TAG_W]    = tag;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    settle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    total++;
    if (rsp_valid !== 2'b00) begin
      bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid);
    end
    total++;
    if ({alu_ctrl, alu_reg_data1, alu_reg_data2, alu_imm, alu_alusrc} !== '0) begin
      bad++; $display("FAIL reset_alu_outputs: got ctrl %h d1 %h d2 %h want zeros",
                      alu_ctrl, alu_reg_data1, alu_reg_data2);
    end
    req_valid = 2'b11;
    settle();
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL reset_first_grant: got %b want 01", req_ready);
    end
    idle();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 2'b01;
    set_req(0, 4'b0010, 32'd10, 32'd3, 32'd0, 1'b0, 4'd5);
    settle();
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL single_ready: got %b want 01", req_ready);
    end
    tick();
    idle();
    settle();
    total++;
    if ({alu_ctrl, alu_reg_data1, alu_reg_data2, rsp_valid} !== {4'b0010, 32'd10, 32'd3, 2'b00}) begin
      bad++; $display("FAIL single_issue: got ctrl %h a %0d b %0d rsp %b want 2 10 3 00",
                      alu_ctrl, alu_reg_data1, alu_reg_data2, rsp_valid);
    end
    tick();
    settle();
    total++;
    if ({rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag} !== {2'b01, 32'd7, 1'b0, 1'b0, 4'd5}) begin
      bad++; $display("FAIL single_rsp: got v %b res %0d z %b e %b tag %0d want 01 7 0 0 5",
                      rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag);
    end
    tick();
  endtask

  task automatic test_grants();
    int exp_g [4];
    logic [1:0] oh;
    logic [TAG_W-1:0] et;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        req_valid = 2'b11;
        set_req(0, 4'b0010, 32'(100 + k), 32'(k), '0, 1'b0, TAG_W'(k));
        set_req(1, 4'b0001, 32'(k), 32'h10, '0, 1'b0, TAG_W'(8 + k));
      end else req_valid = 2'b00;
      settle();
      if (k < 4) begin
        oh = 2'b01 << exp_g[k];
        total++;
        if (req_ready !== oh) begin
          bad++; $display("FAIL grant_seq[%0d]: got %b want %b", k, req_ready, oh);
        end
      end
      if (k >= 2) begin
        oh = 2'b01 << exp_g[k-2];
        et = (exp_g[k-2] == 0) ? TAG_W'(k - 2) : TAG_W'(8 + k - 2);
        total++;
        if ({rsp_valid, rsp_tag} !== {oh, et}) begin
          bad++; $display("FAIL rsp_order[%0d]: got v %b tag %0d want v %b tag %0d",
                          k - 2, rsp_valid, rsp_tag, oh, et);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [TAG_W-1:0] q[$];
    logic [TAG_W-1:0] want;
    int nt, delivered;
    nt = 0;
    delivered = 0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      rsp_ready = {1'b1, !(c >= 4 && c < 7)};
      req_valid = (c < 8) ? 2'b01 : 2'b00;
      set_req(0, legal_ops[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), TAG_W'(nt));
      settle();
      total++;
      if ({req_ready, rsp_valid} !== {exp_req_ready, exp_rsp_valid}) begin
        bad++; $display("FAIL bp_handshake[%0d]: got ready %b rsp %b want %b %b",
                        c, req_ready, rsp_valid, exp_req_ready, exp_rsp_valid);
      end
      if (c >= 4 && c < 7) begin
        total++;
        if ({req_ready, rsp_valid, rsp_tag} !== {2'b00, 2'b01, TAG_W'(2)}) begin
          bad++; $display("FAIL bp_stall[%0d]: got ready %b rsp %b tag %0d want 00 01 2",
                          c, req_ready, rsp_valid, rsp_tag);
        end
      end
      if (exp_rsp_valid[0] && rsp_ready[0]) begin
        want = (q.size() > 0) ? q.pop_front() : '1;
        total++;
        if ({rsp_tag, rsp_result} !== {want, m_s2.result}) begin
          bad++; $display("FAIL bp_deliver[%0d]: got tag %0d res %h want %0d %h",
                          c, rsp_tag, rsp_result, want, m_s2.result);
        end
        delivered++;
      end
      if (exp_req_ready[0]) begin
        q.push_back(TAG_W'(nt));
        nt++;
      end
      tick();
    end
    total++;
    if (q.size() != 0 || delivered != 5) begin
      bad++; $display("FAIL bp_count: got delivered %0d pending %0d want 5 0", delivered, q.size());
    end
    idle();
  endtask

  task automatic test_illegal();
    do_reset();
    req_valid = 2'b10;
    set_req(1, 4'b1111, 32'h1234, 32'h5678, 32'h9, 1'b0, 4'd9);
    settle();
    total++;
    if (req_ready !== 2'b10) begin
      bad++; $display("FAIL illegal_ready: got %b want 10", req_ready);
    end
    tick();
    idle();
    settle();
    total++;
    if (alu_ctrl !== 4'b0000) begin
      bad++; $display("FAIL illegal_ctrl: got %b want 0000", alu_ctrl);
    end
    tick();
    settle();
    total++;
    if ({rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_err, rsp_tag} !==
        {2'b10, 32'd0, 1'b1, 1'b0, 1'b1, 4'd9}) begin
      bad++; $display("FAIL illegal_rsp: got v %b res %h z %b o %b e %b tag %0d want 10 0 1 0 1 9",
                      rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_err, rsp_tag);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 2'b01;
    set_req(0, 4'b0001, 32'h1, 32'h2, '0, 1'b0, 4'd1);
    tick();
    set_req(0, 4'b0001, 32'h3, 32'h4, '0, 1'b0, 4'd2);
    tick();
    req_valid = 2'b10;
    flush = 2'b01;
    set_req(1, 4'b0001, 32'hf0, 32'h0f, '0, 1'b0, 4'd7);
    settle();
    total++;
    if (req_ready !== 2'b10) begin
      bad++; $display("FAIL flush_accept_other: got %b want 10", req_ready);
    end
    tick();
    idle();
    settle();
    total++;
    if ({rsp_valid, alu_ctrl} !== {2'b00, 4'b0001}) begin
      bad++; $display("FAIL flush_dropped: got rsp %b ctrl %b want 00 0001", rsp_valid, alu_ctrl);
    end
    tick();
    settle();
    total++;
    if ({rsp_valid, rsp_tag, rsp_result} !== {2'b10, 4'd7, 32'hff}) begin
      bad++; $display("FAIL flush_other_rsp: got v %b tag %0d res %h want 10 7 ff",
                      rsp_valid, rsp_tag, rsp_result);
    end
    tick();
    settle();
    total++;
    if (rsp_valid !== 2'b00) begin
      bad++; $display("FAIL flush_no_extra: got %b want 00", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    set_req(0, 4'b0010, 32'd9, 32'd1, '0, 1'b0, 4'd3);
    tick();
    set_req(0, 4'b0001, 32'd9, 32'd1, '0, 1'b0, 4'd4);
    tick();
    req_valid = 2'b00;
    rst_n = 1'b0;
    settle();
    tick();
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    settle();
    total++;
    if ({rsp_valid, alu_ctrl} !== {2'b00, 4'b0000}) begin
      bad++; $display("FAIL reset_mid_flushed: got rsp %b ctrl %b want 00 0000", rsp_valid, alu_ctrl);
    end
    req_valid = 2'b11;
    settle();
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL reset_mid_lp: got %b want 01", req_ready);
    end
    idle();
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [WIDTH-1:0] a, b;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 2; i++) begin
        flush[i]     = ($urandom_range(0, 15) == 0);
        req_valid[i] = !flush[i] && ($urandom_range(0, 3) != 0);
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
        op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 4)];
        b  = $urandom;
        a  = ($urandom_range(0, 3) == 0) ? b : $urandom;
        set_req(i, op, a, b, $urandom, 1'($urandom_range(0, 1)), TAG_W'($urandom));
      end
      settle();
      total++;
      if ({req_ready, rsp_valid, alu_ctrl} !==
          {exp_req_ready, exp_rsp_valid, m_s1.valid ? m_s1.ctrl : 4'b0000}) begin
        bad++; $display("FAIL rand_ctrl[%0d]: got ready %b rsp %b ctrl %b want %b %b %b", c,
                        req_ready, rsp_valid, alu_ctrl, exp_req_ready, exp_rsp_valid,
                        m_s1.valid ? m_s1.ctrl : 4'b0000);
      end
      total++;
      if ({alu_reg_data1, alu_reg_data2, alu_imm, alu_alusrc} !==
          (m_s1.valid ? {m_s1.a, m_s1.b, m_s1.imm, m_s1.alusrc} : {(3*WIDTH+1){1'b0}})) begin
        bad++; $display("FAIL rand_alu_data[%0d]: got %h %h %h %b want %h %h %h", c,
                        alu_reg_data1, alu_reg_data2, alu_imm, alu_alusrc, m_s1.a, m_s1.b, m_s1.imm);
      end
      if (exp_rsp_valid != 2'b00) begin
        total++;
        if ({rsp_result, rsp_zero, rsp_overflow, rsp_err, rsp_tag} !==
            {m_s2.result, m_s2.zero, m_s2.ovf, m_s2.err, m_s2.tag}) begin
          bad++; $display("FAIL rand_rsp[%0d]: got %h z%b o%b e%b t%0d want %h z%b o%b e%b t%0d", c,
                          rsp_result, rsp_zero, rsp_overflow, rsp_err, rsp_tag,
                          m_s2.result, m_s2.zero, m_s2.ovf, m_s2.err, m_s2.tag);
        end
      end
      tick();
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_grants();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single pipeline ALU between two requesters (index 0: EX-stage integer path; index 1: branch/compare path). Each request carries operands, ALUsrc and a 4-bit ALU control code. Requests are arbitrated round-robin and issued through a two-stage registered pipe: issue register, then result register. Each result returns to its requester with a tag, under valid/ready handshakes and per-requester flush.

## Interface
Parameters:
- WIDTH, 32, datapath width
- TAG_W, 4, request tag width

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted when valid&ready
- req_op  in  2*4  ALU control code per requester
- req_a, req_b, req_imm  in  2*WIDTH each  reg_data1, reg_data2, immediate
- req_alusrc  in  2  1 = use immediate as second operand
- req_tag  in  2*TAG_W  opaque tag, echoed in response
- flush  in  2  kill all in-flight work of requester i
- alu_reg_data1, alu_reg_data2, alu_imm  out  WIDTH each  to ALU
- alu_alusrc  out  1  to ALU
- alu_ctrl  out  4  to ALU control_signals
- alu_result  in  WIDTH  from ALU, combinational
- alu_zero, alu_overflow  in  1 each  from ALU
- rsp_valid  out  2  response valid, one-hot or zero
- rsp_ready  in  2  response accept per requester
- rsp_result  out  WIDTH;  rsp_zero, rsp_overflow, rsp_err  out  1 each;  rsp_tag  out  TAG_W

## Operation
- Legal ops: 0000 AND, 0001 OR, 0010 SUB, 0110 SLT, 1100 NOR. Any other code is illegal.
- Stage S1 (issue reg): valid, owner, op, operands, tag. Drives alu_* outputs directly. When S1 is invalid, alu_ctrl = 0000 and data outputs = 0.
- Stage S2 (result reg): valid, owner, result, zero, overflow, err, tag. rsp_valid[owner] = S2.valid.
- Illegal op: S1 forces alu_ctrl to 0000. S2 captures result 0, zero 1, overflow 0, err 1.
- advance = ~S2.valid | rsp_ready[S2.owner]. S1 moves to S2 only on advance; otherwise S1 and S2 hold.
- s1_free = ~S1.valid | advance. req_ready[i] = grant[i] & s1_free & ~flush[i]. At most one bit is set.
- Round-robin arbitration: last-grant pointer lp. With both requesting, grant goes to ~lp. lp updates only on an accepted handshake.
- Flush: flush[i] invalidates S1 and/or S2 entries owned by i in that cycle. Flush beats advance and response acceptance, and blocks new acceptance from i that cycle. Flushed S1 content never reaches S2.
- Widths: operands, result and tag pass unmodified; no extension.

## Timing
- Reset (rst_n low at edge): S1.valid = S2.valid = 0, lp = 1 (requester 0 wins first), so all rsp_valid = 0 and alu_* outputs = 0.
- Reset mid-operation discards all in-flight entries; no response is emitted for them.
- Latency: accept at edge N → ALU inputs valid cycle N+1 → rsp_valid high cycle N+2.
- Throughput: 1 op/cycle while the addressed rsp_ready stays high.
- rsp_* are stable while rsp_valid is high and not accepted.
- With rsp_ready low and S1 full, req_ready = 0 for both requesters.
- Same-cycle accept into S1 and drain of S2 is allowed.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: requester 0 always wins when both are valid; lp is removed.
  - Undefined: round-robin as described.
- Reset, latency and flush behaviour are identical in both builds.

## Structure
- Package alu_pkg:
  - alu_op_t (4-bit) and constants ALU_AND, ALU_OR, ALU_SUB, ALU_SLT, ALU_NOR
  - function is_legal_op
  - localparam NREQ = 2
- Sub-module alu_rr_arbiter: 2-way round-robin/fixed-priority grant with lp register. Inputs req, advance-qualified accept; output grant.
- The ALU itself is instantiated outside this block.

## Test plan
- Reset then single request from req 0, op 0010, a = 10, b = 3, tag = 5 → rsp_valid = 01 two cycles later with result 7, zero 0, tag 5.
- Both requesters valid for 4 cycles, rsp_ready = 11 → grants 0,1,0,1 (with ALU_ARB_FIXED_PRIO_EN: 0,0,0,0) and responses in the same order.
- Response backpressure: rsp_ready[0] = 0 for 3 cycles with a stream pending → S2 holds stable, S1 holds, req_ready = 00. Stream resumes with no loss or duplication.
- Illegal op 1111 from req 1 → alu_ctrl = 0000, response has err 1, result 0, zero 1.
- flush[0] while req 0 owns both S1 and S2, and req 1 is valid → both entries dropped, no rsp for req 0, req 1 accepted that cycle.
- rst_n low for 1 cycle with S1/S2 full → next cycle all rsp_valid = 0 and lp = 1.
